// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, instruction-class codes and per-entry metadata for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE_DEF = 16;
  localparam int unsigned ROB_BW_DEF   = 4;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_BRC   = 3'd3,
    CLS_JUMP  = 3'd4
  } inst_class_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  kind;
    logic        mispredict;
    logic [31:0] target;
  } rob_meta_t;

endpackage

// File: rtl/reorder_buffer_query.sv
// Combinational operand lookup: same-cycle CDB broadcast wins over stored results.
module reorder_buffer_query
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE = ROB_SIZE_DEF,
  parameter int unsigned ROB_BW   = ROB_BW_DEF
) (
  input  logic [ROB_BW-1:0]              id,
  input  logic [ROB_SIZE-1:0]            done,
  input  logic [ROB_SIZE-1:0][31:0]      value_mem,
  input  logic                           cdb_valid,
  input  logic [ROB_BW-1:0]              cdb_rob_id,
  input  logic [31:0]                    cdb_value,
  output logic                           ready,
  output logic [31:0]                    value
);

  always_comb begin
    ready = 1'b0;
    value = '0;
    if (cdb_valid && (cdb_rob_id == id)) begin
      ready = 1'b1;
      value = cdb_value;
    end else if (done[id]) begin
      ready = 1'b1;
      value = value_mem[id];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates ids at dispatch, captures CDB results,
// retires one entry per cycle in program order and flushes on a mispredicted branch.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE = ROB_SIZE_DEF,
  parameter int unsigned ROB_BW   = ROB_BW_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              rdy_in,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [2:0]        issue_type,
  input  logic [31:0]       issue_pc,
  output logic              rob_full,
  output logic [ROB_BW-1:0] issue_rob_id,
  input  logic              cdb_valid,
  input  logic [ROB_BW-1:0] cdb_rob_id,
  input  logic [31:0]       cdb_value,
  input  logic              cdb_mispredict,
  input  logic [31:0]       cdb_target,
  input  logic [ROB_BW-1:0] qry1_id,
  input  logic [ROB_BW-1:0] qry2_id,
  output logic              qry1_ready,
  output logic              qry2_ready,
  output logic [31:0]       qry1_value,
  output logic [31:0]       qry2_value,
  output logic              commit_valid,
  output logic [ROB_BW-1:0] commit_rob_id,
  output logic [4:0]        commit_rd,
  output logic [31:0]       commit_value,
  output logic [2:0]        commit_type,
  output logic              flush_out,
  output logic [31:0]       flush_pc
);

  logic [ROB_BW-1:0]         head;
  logic [ROB_BW-1:0]         tail;
  logic [ROB_BW:0]           count;
  logic [ROB_SIZE-1:0]       busy;
  logic [ROB_SIZE-1:0]       done;
  logic [ROB_SIZE-1:0][31:0] value_mem;
  logic [ROB_SIZE-1:0][31:0] pc_mem;
  rob_meta_t                 meta [ROB_SIZE];

  logic issue_fire;
  logic cdb_fire;
  logic commit_fire;
  logic flush_fire;

  assign rob_full     = (count == (ROB_BW + 1)'(ROB_SIZE));
  assign issue_rob_id = tail;

  // Commit looks only at registered state, so a CDB hitting head this cycle retires next cycle.
  assign issue_fire  = rdy_in & issue_valid & ~rob_full;
  assign cdb_fire    = rdy_in & cdb_valid & busy[cdb_rob_id];
  assign commit_fire = rdy_in & busy[head] & done[head];
  assign flush_fire  = commit_fire & meta[head].mispredict;

  // Instruction pc is kept per entry for debug visibility only.
  logic unused_pc;
  assign unused_pc = ^pc_mem;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_fire) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (issue_fire)  tail <= tail + ROB_BW'(1);
      if (commit_fire) head <= head + ROB_BW'(1);
      case ({issue_fire, commit_fire})
        2'b10:   count <= count + (ROB_BW + 1)'(1);
        2'b01:   count <= count - (ROB_BW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      done <= '0;
    end else if (flush_fire) begin
      busy <= '0;
      done <= '0;
    end else begin
      if (issue_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
      end
      if (cdb_fire) done[cdb_rob_id] <= 1'b1;
      if (commit_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
      end
    end
  end

  // Payload is only consumed behind busy/done, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (issue_fire) begin
      meta[tail].rd   <= issue_rd;
      meta[tail].kind <= issue_type;
      pc_mem[tail]    <= issue_pc;
    end
    if (cdb_fire) begin
      value_mem[cdb_rob_id]       <= cdb_value;
      meta[cdb_rob_id].mispredict <= cdb_mispredict;
      meta[cdb_rob_id].target     <= cdb_target;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid  <= 1'b0;
      commit_rob_id <= '0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_type   <= '0;
      flush_out     <= 1'b0;
      flush_pc      <= '0;
    end else begin
      commit_valid <= commit_fire;
      flush_out    <= flush_fire;
      if (commit_fire) begin
        commit_rob_id <= head;
        commit_rd     <= meta[head].rd;
        commit_value  <= value_mem[head];
        commit_type   <= meta[head].kind;
      end
      if (flush_fire) flush_pc <= meta[head].target;
    end
  end

  reorder_buffer_query #(.ROB_SIZE(ROB_SIZE), .ROB_BW(ROB_BW)) u_query1 (
    .id         (qry1_id),
    .done       (done),
    .value_mem  (value_mem),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .ready      (qry1_ready),
    .value      (qry1_value)
  );

  reorder_buffer_query #(.ROB_SIZE(ROB_SIZE), .ROB_BW(ROB_BW)) u_query2 (
    .id         (qry2_id),
    .done       (done),
    .value_mem  (value_mem),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .ready      (qry2_ready),
    .value      (qry2_value)
  );

endmodule
